// File: rtl/aha_tlx_pkg.sv
// Shared definitions for the TLX training transmitter: FSM encoding and default word width.
package aha_tlx_pkg;

    localparam int unsigned SEQ_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        TRAINING = 2'b01,
        FINISH   = 2'b10
    } tlx_state_e;

endpackage

// File: rtl/aha_tlx_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse for each 0->1 transition of D.
module aha_tlx_rise_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic D,
    output logic RISE
);

    logic d_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) d_q <= 1'b0;
        else       d_q <= D;
    end

    assign RISE = D & ~d_q;

endmodule

// File: rtl/aha_tlx_training_tx.sv
// TLX training-sequence transmitter: repeats a latched word LSB-first on D_OUT,
// optionally stopping after LENGTH complete words.
module aha_tlx_training_tx
    import aha_tlx_pkg::*;
#(
    parameter int unsigned SEQ_WIDTH = SEQ_WIDTH_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 CLEAR,
    input  logic [SEQ_WIDTH-1:0] SEQUENCE,
    input  logic [31:0]          LENGTH,
    input  logic                 AUTO_STOP,
    output logic                 D_OUT,
    output logic                 DONE,
    output logic                 ACTIVE,
    output logic [31:0]          SENT_COUNT
);

    localparam int unsigned IDX_W = $clog2(SEQ_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_WIDTH - 1);

    tlx_state_e state, state_next;

    logic                 start_p;
    logic                 clear_p;
    logic [SEQ_WIDTH-1:0] seq_r;
    logic [IDX_W-1:0]     idx;
    logic                 done_w;
    logic                 accept;
    logic                 d_next;
    logic                 word_end;

    aha_tlx_rise_detect u_start_rise (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (START),
        .RISE  (start_p)
    );

    aha_tlx_rise_detect u_clear_rise (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (CLEAR),
        .RISE  (clear_p)
    );

    // LENGTH and AUTO_STOP are compared live every cycle, never latched.
    assign done_w = (state == TRAINING) && AUTO_STOP && (SENT_COUNT == LENGTH);
    assign accept = (state == IDLE) && start_p && !clear_p;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (start_p && !clear_p) state_next = TRAINING;
            TRAINING: begin
                if (clear_p)     state_next = IDLE;
                else if (done_w) state_next = FINISH;
            end
            FINISH:   state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        ACTIVE   = 1'b0;
        d_next   = 1'b0;
        word_end = 1'b0;
        if (state == TRAINING && !done_w) begin
            ACTIVE   = 1'b1;
            d_next   = seq_r[idx];
            word_end = (idx == IDX_LAST);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            seq_r <= '0;
            idx   <= '0;
            D_OUT <= 1'b0;
        end else begin
            if (accept) seq_r <= SEQUENCE;
            idx   <= (state == TRAINING) ? idx + IDX_W'(1) : '0;
            D_OUT <= d_next;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            SENT_COUNT <= '0;
            DONE       <= 1'b0;
        end else begin
            if (clear_p || accept) SENT_COUNT <= '0;
            else if (word_end)     SENT_COUNT <= SENT_COUNT + 32'd1;

            if (done_w)                DONE <= 1'b1;
            else if (clear_p || accept) DONE <= 1'b0;
        end
    end

endmodule

// File: doc/aha_tlx_training_tx.md
AHA_TLX_TRAINING_TX -- requirements
Module: aha_tlx_training_tx

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL declare these parameters (name, default, meaning):
- SEQ_WIDTH, 32, training word width; must be a power of two, 2 to 32.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  level; its rising edge starts transmission.
- CLEAR  in  1  level; its rising edge aborts transmission and clears DONE/SENT_COUNT.
- SEQUENCE  in  SEQ_WIDTH  training word to transmit.
- LENGTH  in  32  number of complete words to send when AUTO_STOP=1.
- AUTO_STOP  in  1  1: stop after LENGTH words; 0: run until CLEAR.
- D_OUT  out  1  serial TLX training data, registered.
- DONE  out  1  sticky; auto-stop completed.
- ACTIVE  out  1  transmission in progress.
- SENT_COUNT  out  32  number of complete words transmitted.

Function
REQ-004 Each of START and CLEAR SHALL pass through a registered rising-edge detector; pulse = in & ~in_q, with a one-cycle-wide pulse per 0->1 transition.
REQ-005 The FSM SHALL have the states IDLE, TRAINING and FINISH.
- IDLE->TRAINING on start pulse without clear pulse.
- TRAINING->IDLE on clear pulse.
- TRAINING->FINISH when done_w (AUTO_STOP=1 and SENT_COUNT==LENGTH).
- FINISH->IDLE unconditionally.
REQ-006 A clear pulse SHALL win over a simultaneous start pulse.
REQ-007 A start pulse in TRAINING or FINISH SHALL be ignored; there is no restart.
REQ-008 On the IDLE->TRAINING edge, SEQUENCE SHALL be latched into seq_r; later SEQUENCE changes SHALL have no effect until the next start.
REQ-009 A $clog2(SEQ_WIDTH)-bit bit index SHALL behave as follows:
- Resets to 0 outside TRAINING.
- Increments every TRAINING cycle.
- Wraps from SEQ_WIDTH-1 to 0.
REQ-010 In a TRAINING cycle without done_w, D_OUT SHALL be updated at the next edge to seq_r[idx], so the word is sent LSB-first and D_OUT lags idx by 1 cycle. In all other cycles D_OUT SHALL be updated to 0.
REQ-011 This LSB-first ordering SHALL make the receiver's shift-in-at-LSB register, bit-reversed, equal SEQUENCE.
REQ-012 SENT_COUNT SHALL increment when state==TRAINING and idx==SEQ_WIDTH-1 and done_w is not asserted.
- SENT_COUNT is cleared by a clear pulse or a start pulse accepted in IDLE.
- SENT_COUNT wraps modulo 2^32 when AUTO_STOP=0.
REQ-013 DONE SHALL set on done_w and SHALL clear only on a clear pulse or a start pulse accepted in IDLE; set has priority.
REQ-014 ACTIVE SHALL equal (state==TRAINING) & ~done_w.
REQ-015 LENGTH=0 with AUTO_STOP=1 SHALL produce one TRAINING cycle with done_w, then FINISH. No bits are sent, D_OUT stays 0, and DONE=1.
REQ-016 LENGTH and AUTO_STOP SHALL be sampled live, not latched. Lowering AUTO_STOP mid-run continues transmission. Raising AUTO_STOP after SENT_COUNT has passed LENGTH runs until the count wraps or CLEAR.

Reset
REQ-017 While RESET=1, the following SHALL hold:
- state=IDLE, idx=0, seq_r=0, D_OUT=0, DONE=0, ACTIVE=0, SENT_COUNT=0.
- Edge-detector history registers are 0, so a START held high through reset release produces a start pulse on the first cycle after release.
REQ-018 Reset asserted mid-transmission SHALL abort immediately and asynchronously to the values in REQ-017.

Structure
REQ-019 The state encodings (IDLE=2'b00, TRAINING=2'b01, FINISH=2'b10) and the SEQ_WIDTH default SHALL live in the shared package aha_tlx_pkg.
REQ-020 The edge detector SHALL be a separate sub-module aha_tlx_rise_detect (CLK, RESET, D, RISE), instantiated twice.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- SEQUENCE=32'hA5A5_0F0F, LENGTH=2, AUTO_STOP=1, START 0->1 -> D_OUT emits 64 bits LSB-first (1,1,1,1,0,0,0,0,...); SENT_COUNT=2; DONE=1; ACTIVE=0; D_OUT=0 afterwards.
- Loopback into the receiver capsule with LENGTH=4 -> receiver MATCH_COUNT>=4 and receiver DONE asserted.
- AUTO_STOP=0, CLEAR pulse after 100 cycles -> SENT_COUNT=3 before the clear, then 0; state IDLE; DONE stays 0.
- LENGTH=0, AUTO_STOP=1, START -> DONE=1 within 3 cycles; D_OUT never 1.
- START and CLEAR rising in the same cycle -> stays IDLE. START re-pulsed during TRAINING -> no restart (idx continues).
- RESET asserted at bit 17 of word 1 -> all outputs 0 immediately. After release, START held high -> a new transmission begins.
